// File: rtl/cla_adder_checker_if.sv
// Operand/result bus between the sweep checker and the carry-lookahead adder under test.
`default_nettype none

interface cla_adder_checker_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] dut_a;
  logic [WIDTH-1:0] dut_b;
  logic             dut_ci;
  logic [WIDTH-1:0] dut_sum;
  logic             dut_co;

  modport master (output dut_a, output dut_b, output dut_ci, input dut_sum, input dut_co);
  modport slave  (input dut_a, input dut_b, input dut_ci, output dut_sum, output dut_co);
endinterface

`default_nettype wire

// File: rtl/cla_adder_checker.sv
// ============================================================================
// Module  : cla_adder_checker
// Purpose : Exhaustive {A,B,CI} sweep of an adder with golden compare, error
//           count and first-failure capture.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module cla_adder_checker #(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  wire logic                 clk,
  input  wire logic                 rst,
  input  wire logic                 start,
  cla_adder_checker_if.master       bus,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [2*WIDTH+1:0]        err_count,
  output logic [2*WIDTH+1:0]        vec_count,
  output logic [WIDTH-1:0]          fail_a,
  output logic [WIDTH-1:0]          fail_b,
  output logic                      fail_ci,
  output logic                      fail_valid
);

  localparam int IW = 2 * WIDTH + 1;
  localparam int CNTW = 2 * WIDTH + 2;
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRIVE = 3'd1,
    S_WAIT  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [CNTW-1:0]   err_q, err_d;
  logic [CNTW-1:0]   vec_q, vec_d;
  logic [WIDTH-1:0]  fa_q, fa_d;
  logic [WIDTH-1:0]  fb_q, fb_d;
  logic              fci_q, fci_d;
  logic              fv_q, fv_d;

  // The index register is the drive register: {a, b, ci} with ci as LSB.
  logic [WIDTH-1:0]  cur_a;
  logic [WIDTH-1:0]  cur_b;
  logic              cur_ci;
  logic [WIDTH:0]    sum_exp;
  logic              mismatch;

  assign cur_a    = idx_q[IW-1 -: WIDTH];
  assign cur_b    = idx_q[WIDTH:1];
  assign cur_ci   = idx_q[0];
  assign sum_exp  = {1'b0, cur_a} + {1'b0, cur_b} + {{WIDTH{1'b0}}, cur_ci};
  assign mismatch = ({bus.dut_co, bus.dut_sum} != sum_exp);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    vec_d   = vec_q;
    fa_d    = fa_q;
    fb_d    = fb_q;
    fci_d   = fci_q;
    fv_d    = fv_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_DRIVE;
          idx_d   = '0;
          cnt_d   = '0;
          err_d   = '0;
          vec_d   = '0;
          fa_d    = '0;
          fb_d    = '0;
          fci_d   = 1'b0;
          fv_d    = 1'b0;
          done_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end
      S_DRIVE: begin
        cnt_d = '0;
        if (SETTLE_CYCLES > 0) state_d = S_WAIT;
        else                   state_d = S_CHECK;
      end
      S_WAIT: begin
        if (cnt_q == WAIT_LAST) state_d = S_CHECK;
        else                    cnt_d   = cnt_q + 1'b1;
      end
      S_CHECK: begin
        vec_d = vec_q + 1'b1;
        if (mismatch) begin
          if (err_q != '1) err_d = err_q + 1'b1;
          if (!fv_q) begin
            fa_d  = cur_a;
            fb_d  = cur_b;
            fci_d = cur_ci;
            fv_d  = 1'b1;
          end
        end
        if (idx_q == '1) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_DRIVE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= '0;
      vec_q   <= '0;
      fa_q    <= '0;
      fb_q    <= '0;
      fci_q   <= 1'b0;
      fv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      vec_q   <= vec_d;
      fa_q    <= fa_d;
      fb_q    <= fb_d;
      fci_q   <= fci_d;
      fv_q    <= fv_d;
    end
  end

  assign bus.dut_a  = cur_a;
  assign bus.dut_b  = cur_b;
  assign bus.dut_ci = cur_ci;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = done_q && (err_q == '0);
  assign err_count  = err_q;
  assign vec_count  = vec_q;
  assign fail_a     = fa_q;
  assign fail_b     = fb_q;
  assign fail_ci    = fci_q;
  assign fail_valid = fv_q;

endmodule

`default_nettype wire

// File: tb/tb_cla_adder_checker.sv
// Bench for cla_adder_checker: behavioural adder with injectable faults, two
// checker instances (SETTLE_CYCLES=1 and 0), queue-based result scoreboard.
`default_nettype none

module tb_cla_adder_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start1 = 1'b0;
  logic start0 = 1'b0;
  logic [1:0] mode = 2'd0;
  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         done_cyc;
    int         err;
    logic       fv;
    logic [3:0] fa;
    logic [3:0] fb;
    logic       fci;
  } exp_t;

  exp_t q1[$];
  exp_t q0[$];

  cla_adder_checker_if #(.WIDTH(4)) bus1 ();
  cla_adder_checker_if #(.WIDTH(4)) bus0 ();

  // Behavioural adders; instance 1 can have CO or SUM[0] stuck at 0.
  logic [4:0] r1;
  logic [4:0] r0;
  always_comb begin
    r1 = {1'b0, bus1.dut_a} + {1'b0, bus1.dut_b} + {4'd0, bus1.dut_ci};
    if (mode == 2'd1) r1[4] = 1'b0;
    if (mode == 2'd2) r1[0] = 1'b0;
    r0 = {1'b0, bus0.dut_a} + {1'b0, bus0.dut_b} + {4'd0, bus0.dut_ci};
  end
  assign bus1.dut_sum = r1[3:0];
  assign bus1.dut_co  = r1[4];
  assign bus0.dut_sum = r0[3:0];
  assign bus0.dut_co  = r0[4];

  logic busy1, done1, pass1, fa_ci1, fv1;
  logic [9:0] err1, vec1;
  logic [3:0] fa1, fb1;
  logic busy0, done0, pass0, fa_ci0, fv0;
  logic [9:0] err0, vec0;
  logic [3:0] fa0, fb0;

  cla_adder_checker #(.WIDTH(4), .SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .bus(bus1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .vec_count(vec1),
    .fail_a(fa1), .fail_b(fb1), .fail_ci(fa_ci1), .fail_valid(fv1)
  );

  cla_adder_checker #(.WIDTH(4), .SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .bus(bus0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .vec_count(vec0),
    .fail_a(fa0), .fail_b(fb0), .fail_ci(fa_ci0), .fail_valid(fv0)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic cmp_res(input string tag, input exp_t e, input logic pass_a,
                         input logic [9:0] err_a, input logic [9:0] vec_a,
                         input logic fv_a, input logic [3:0] fa_a,
                         input logic [3:0] fb_a, input logic fci_a);
    chk({tag, "_done_cycle"}, cyc, e.done_cyc);
    chk({tag, "_pass"}, {31'd0, pass_a}, {31'd0, e.err == 0});
    chk({tag, "_err_count"}, {22'd0, err_a}, e.err);
    chk({tag, "_vec_count"}, {22'd0, vec_a}, 512);
    chk({tag, "_fail_valid"}, {31'd0, fv_a}, {31'd0, e.fv});
    chk({tag, "_fail_abc"}, {23'd0, fa_a, fb_a, fci_a}, {23'd0, e.fa, e.fb, e.fci});
  endtask

  function automatic exp_t mk(input int dc, input int err, input logic fv,
                              input logic [3:0] fa, input logic [3:0] fb, input logic fci);
    exp_t e;
    e.done_cyc = dc; e.err = err; e.fv = fv; e.fa = fa; e.fb = fb; e.fci = fci;
    return e;
  endfunction

  // Scoreboard monitors: pop an expectation on each rising done.
  logic done1_prev = 1'b0;
  logic done0_prev = 1'b0;
  exp_t e1, e0;

  always @(negedge clk) begin
    if (done1 && !done1_prev) begin
      if (q1.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_done1: got done at cycle %0d, expected none", cyc);
      end else begin
        e1 = q1.pop_front();
        cmp_res("s1", e1, pass1, err1, vec1, fv1, fa1, fb1, fa_ci1);
      end
    end
    done1_prev <= done1;
  end

  always @(negedge clk) begin
    if (done0 && !done0_prev) begin
      if (q0.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_done0: got done at cycle %0d, expected none", cyc);
      end else begin
        e0 = q0.pop_front();
        cmp_res("s0", e0, pass0, err0, vec0, fv0, fa0, fb0, fa_ci0);
      end
    end
    done0_prev <= done0;
  end

  task automatic pulse_start1(output int acc);
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    acc = cyc;
  endtask

  task automatic pulse_start0(output int acc);
    @(posedge clk); #1 start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    acc = cyc;
  endtask

  task automatic wait_done1(input int lim);
    for (int i = 0; i < lim && !done1; i++) @(negedge clk);
    chk("done1_reached", {31'd0, done1}, 32'd1);
    repeat (2) @(posedge clk);
  endtask

  task automatic wait_done0(input int lim);
    for (int i = 0; i < lim && !done0; i++) @(negedge clk);
    chk("done0_reached", {31'd0, done0}, 32'd1);
    repeat (2) @(posedge clk);
  endtask

  task automatic wait_vec1(input int target, input int lim);
    for (int i = 0; i < lim && vec1 != 10'(target); i++) begin
      @(posedge clk); #1;
    end
    chk("vec1_reached", {22'd0, vec1}, target);
  endtask

  initial begin
    int t;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_done", {31'd0, done1}, 0);
    chk("rst_busy", {31'd0, busy1}, 0);
    chk("rst_pass", {31'd0, pass1}, 0);
    chk("rst_counts", {12'd0, err1, vec1}, 0);
    chk("rst_fail", {22'd0, fv1, fa1, fb1, fa_ci1}, 0);
    chk("rst_drive", {23'd0, bus1.dut_a, bus1.dut_b, bus1.dut_ci}, 0);

    // Correct adder, settle 1
    mode = 2'd0;
    pulse_start1(t);
    q1.push_back(mk(t + 1536, 0, 1'b0, 4'd0, 4'd0, 1'b0));
    chk("start_busy", {31'd0, busy1}, 1);
    chk("start_done", {31'd0, done1}, 0);
    wait_done1(2000);

    // CO stuck at 0
    mode = 2'd1;
    pulse_start1(t);
    q1.push_back(mk(t + 1536, 256, 1'b1, 4'd0, 4'd15, 1'b1));
    wait_done1(2000);

    // SUM[0] stuck at 0
    mode = 2'd2;
    pulse_start1(t);
    q1.push_back(mk(t + 1536, 256, 1'b1, 4'd0, 4'd0, 1'b1));
    wait_done1(2000);

    // Zero settle: a new vector every two cycles
    mode = 2'd0;
    pulse_start0(t);
    q0.push_back(mk(t + 1024, 0, 1'b0, 4'd0, 4'd0, 1'b0));
    chk("s0_seq0", {23'd0, bus0.dut_a, bus0.dut_b, bus0.dut_ci}, 0);
    for (int j = 1; j <= 3; j++) begin
      repeat (2) @(posedge clk);
      #1 chk("s0_seq", {23'd0, bus0.dut_a, bus0.dut_b, bus0.dut_ci}, j);
    end
    wait_done0(1500);

    // Reset mid-sweep while errors are accumulating
    mode = 2'd2;
    pulse_start1(t);
    wait_vec1(100, 400);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("abort_counts", {12'd0, err1, vec1}, 0);
    chk("abort_flags", {29'd0, busy1, done1, fv1}, 0);
    chk("abort_drive", {23'd0, bus1.dut_a, bus1.dut_b, bus1.dut_ci}, 0);
    mode = 2'd0;
    pulse_start1(t);
    q1.push_back(mk(t + 1536, 0, 1'b0, 4'd0, 4'd0, 1'b0));
    wait_done1(2000);

    // start while busy is ignored, then re-arm from DONE
    pulse_start1(t);
    q1.push_back(mk(t + 1536, 0, 1'b0, 4'd0, 4'd0, 1'b0));
    wait_vec1(50, 200);
    start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    chk("ignored_busy", {31'd0, busy1}, 1);
    chk("ignored_vec", {22'd0, vec1}, 50);
    wait_done1(2000);
    chk("done_hold_drive", {23'd0, bus1.dut_a, bus1.dut_b, bus1.dut_ci}, 511);
    pulse_start1(t);
    q1.push_back(mk(t + 1536, 0, 1'b0, 4'd0, 4'd0, 1'b0));
    chk("rearm_done", {31'd0, done1}, 0);
    chk("rearm_vec", {22'd0, vec1}, 0);
    wait_done1(2000);

    repeat (3) @(posedge clk);
    chk("q1_drained", q1.size(), 0);
    chk("q0_drained", q0.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
